shot_clock_counter: RTL
=======================

Name: shot_clock_counter

Overview:
- Countdown stage of the 24 s shot clock; sits directly downstream of the 12 MHz → 1 Hz clock divider.
- Samples the divider's 1 Hz square wave `sec_in` in the `clk` domain and turns each rising edge into a one-cycle tick.
- Counts a two-digit BCD value down once per tick under start/pause/reload control.
- On reaching 00 it raises an expire pulse and a timed buzzer output for the display/LED stage.

Parameters:
- LOAD_BCD, 8'h24, primary reload value, BCD {tens,ones}; each digit must be 0–9 and the value nonzero.
- ALT_BCD, 8'h14, alternate reload value, same rules.
- BUZZ_CYCLES, 24'd12_000_000, buzzer high time in clk cycles (1 s at 12 MHz); must be ≥1.
- BUZZ_W, 24, buzzer counter width; BUZZ_CYCLES must be < 2**BUZZ_W.

Ports:
- clk  in  1  system clock, 12 MHz.
- rst  in  1  reset, asynchronous, active-high.
- sec_in  in  1  1 Hz divided clock from the divider; treated as asynchronous data, never used as a clock.
- start  in  1  level or pulse; begin or resume counting.
- pause  in  1  level or pulse; freeze counting.
- reload  in  1  load LOAD_BCD.
- reload_alt  in  1  load ALT_BCD.
- tens  out  4  BCD tens digit.
- ones  out  4  BCD ones digit.
- running  out  1  high in state RUN.
- expire  out  1  one-cycle pulse when the count reaches 00.
- buzzer  out  1  high for BUZZ_CYCLES cycles after expiry.

Behaviour:
- One clock (`clk`). Reset is asynchronous, active-high (`rst`).
- Reset values:
  - tens/ones = LOAD_BCD; state IDLE; running=0, expire=0, buzzer=0; buzzer counter 0.
  - All three sec_in sampling flops reset to 1, so a high `sec_in` at reset release causes no tick.
- Tick generation:
  - `sec_in` passes through a 2-flop synchronizer, then a third flop for edge detection.
  - tick = s2 & ~s3.
  - A tick is asserted exactly one cycle, in the 3rd rising clk after `sec_in` rises (once setup is met).
  - Only rising edges count.
- States: IDLE, RUN, PAUSE, EXPIRED.
- Command priority, evaluated each cycle: reload > reload_alt > pause > start > tick.
  - reload: any state → IDLE, count=LOAD_BCD, buzzer and buzzer counter cleared, same-cycle tick discarded.
  - reload_alt: the same, with count=ALT_BCD.
  - pause: RUN → PAUSE; ignored in other states.
  - start: IDLE/PAUSE → RUN; ignored in RUN and EXPIRED. start and pause in the same cycle: pause wins.
  - tick in RUN: decrement the count. The tick phase is not realigned on start, so the first decrement occurs 0–1 s after start.
  - tick in IDLE/PAUSE/EXPIRED: ignored; no catch-up later.
- BCD decrement:
  - ones==0 → ones=9, tens=tens-1; else ones=ones-1.
  - Digits never leave 0–9.
  - No decrement ever occurs from 00.
- Expiry:
  - When a RUN tick changes the count from 01 to 00, the next state is EXPIRED.
  - expire=1 for exactly that one cycle (registered, aligned with the count showing 00).
  - buzzer goes high in the same cycle and the counter loads BUZZ_CYCLES.
  - buzzer falls after exactly BUZZ_CYCLES high cycles.
  - State stays EXPIRED with 00 displayed until reload/reload_alt.
- running = (state==RUN), registered with the state.
- Outputs reflect a command on the clock edge that samples it (1-cycle latency from input to output).
- Asserting rst mid-count or mid-buzz clears immediately to the reset values.

Test Plan:
- Reset behaviour: drive sec_in high, assert then release rst → tens=2, ones=4, running=0, buzzer=0; no decrement for 5 cycles with sec_in held high.
- Countdown from start: start pulse, sec_in period 20 clk → count steps 24, 23, …, 20, 19 (ones wraps 0→9 with a tens borrow); each change occurs 3 clk after a sec_in rise.
- Pause/resume: pause at count 17, apply 5 sec_in edges → stays 17; start → next tick gives 16. Same-cycle start+pause → PAUSE.
- Expiry (BUZZ_CYCLES=8): count from 02 → 00 with expire high exactly 1 cycle, buzzer high 8 cycles, state EXPIRED; further ticks and start leave 00.
- Reload priority: reload_alt during RUN at 09 → 14, IDLE. reload+reload_alt+tick in the same cycle → 24, no decrement. reload during buzzer → buzzer=0 next cycle.
- Async reset mid-operation: assert rst between clk edges at count 11 in RUN → outputs go to 24/IDLE before the next clk edge.

Source files
------------

// File: rtl/shot_clock_counter.sv
`default_nettype none
// ============================================================================
// Module   : shot_clock_counter
// Purpose  : 24 s shot-clock BCD countdown, driven by a synchronised 1 Hz tick,
//            with expire pulse and timed buzzer.
// Revision : 1.0
// ============================================================================
module shot_clock_counter #(
    parameter logic [7:0]        LOAD_BCD    = 8'h24,
    parameter logic [7:0]        ALT_BCD     = 8'h14,
    parameter int unsigned       BUZZ_W      = 24,
    parameter logic [BUZZ_W-1:0] BUZZ_CYCLES = 24'd12_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_in,
    input  logic       start,
    input  logic       pause,
    input  logic       reload,
    input  logic       reload_alt,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       expire,
    output logic       buzzer
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [BUZZ_W-1:0] BUZZ_ONE = {{(BUZZ_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [3:0]        tens_q;
    logic [3:0]        ones_q;
    logic              running_q;
    logic              expire_q;
    logic              buzzer_q;
    logic [BUZZ_W-1:0] buzz_cnt_q;

    logic              s1_q;
    logic              s2_q;
    logic              s3_q;
    logic              tick;

    logic [3:0]        tens_d;
    logic [3:0]        ones_d;
    logic              at_one;
    logic              at_zero;

    // Sampling flops reset high so a high sec_in at reset release is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= sec_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign tick = s2_q & ~s3_q;

    always_comb begin
        ones_d = ones_q - 4'd1;
        tens_d = tens_q;
        if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
        end
    end

    assign at_one  = (tens_q == 4'd0) && (ones_q == 4'd1);
    assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tens_q     <= LOAD_BCD[7:4];
            ones_q     <= LOAD_BCD[3:0];
            running_q  <= 1'b0;
            expire_q   <= 1'b0;
            buzzer_q   <= 1'b0;
            buzz_cnt_q <= '0;
        end else begin
            expire_q <= 1'b0;
            if (buzz_cnt_q != '0) begin
                buzz_cnt_q <= buzz_cnt_q - BUZZ_ONE;
                buzzer_q   <= (buzz_cnt_q > BUZZ_ONE);
            end

            // Later assignments below override the buzzer countdown above.
            if (reload) begin
                state_q    <= ST_IDLE;
                tens_q     <= LOAD_BCD[7:4];
                ones_q     <= LOAD_BCD[3:0];
                running_q  <= 1'b0;
                buzzer_q   <= 1'b0;
                buzz_cnt_q <= '0;
            end else if (reload_alt) begin
                state_q    <= ST_IDLE;
                tens_q     <= ALT_BCD[7:4];
                ones_q     <= ALT_BCD[3:0];
                running_q  <= 1'b0;
                buzzer_q   <= 1'b0;
                buzz_cnt_q <= '0;
            end else if (pause) begin
                if (state_q == ST_RUN) begin
                    state_q   <= ST_PAUSE;
                    running_q <= 1'b0;
                end
            end else if (start && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
                state_q   <= ST_RUN;
                running_q <= 1'b1;
            end else if (tick && (state_q == ST_RUN) && !at_zero) begin
                tens_q <= tens_d;
                ones_q <= ones_d;
                if (at_one) begin
                    state_q    <= ST_EXPIRED;
                    running_q  <= 1'b0;
                    expire_q   <= 1'b1;
                    buzzer_q   <= 1'b1;
                    buzz_cnt_q <= BUZZ_CYCLES;
                end
            end
        end
    end

    assign tens    = tens_q;
    assign ones    = ones_q;
    assign running = running_q;
    assign expire  = expire_q;
    assign buzzer  = buzzer_q;

endmodule
`default_nettype wire
